// File: rtl/hyper_txn_sched.sv
// hyper_txn_sched: round-robin scheduler sharing one HyperBus transfer engine
// between NB_REQ requesters. Grants one request at a time, drives the engine
// start/address/size/direction, and reports per-requester completion plus
// read/write end-of-transfer events.
// Optional watchdog/abort path: define HYPER_TXN_SCHED_TIMEOUT_EN.
module hyper_txn_sched #(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SIZE_W = 16,
  parameter int unsigned TO_W   = 16
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_i,
  input  logic [NB_REQ-1:0]          req_valid_i,
  output logic [NB_REQ-1:0]          req_ready_o,
  input  logic [NB_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NB_REQ*SIZE_W-1:0]   req_size_i,
  input  logic [NB_REQ-1:0]          req_rwn_i,
  output logic                       hyp_start_o,
  output logic [ADDR_W-1:0]          hyp_addr_o,
  output logic [SIZE_W-1:0]          hyp_size_o,
  output logic                       hyp_rwn_o,
  input  logic                       hyp_eot_i,
  output logic                       hyp_abort_o,
  input  logic [TO_W-1:0]            timeout_i,
  output logic [NB_REQ-1:0]          done_o,
  output logic [NB_REQ-1:0]          err_o,
  output logic                       rd_eot_o,
  output logic                       wr_eot_o,
  output logic                       busy_o,
  output logic [$clog2(NB_REQ)-1:0]  cur_id_o
);

  localparam int unsigned IdW = $clog2(NB_REQ);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IdW-1:0]    rr_q, rr_d;
  logic [IdW-1:0]    cur_id_q, cur_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              rwn_q, rwn_d;

  logic              grant_any;
  logic              found_hi;
  logic [IdW-1:0]    id_hi, id_lo, grant_id;
  logic [ADDR_W-1:0] grant_addr;
  logic [SIZE_W-1:0] grant_size;
  logic              grant_rwn;
  logic [IdW-1:0]    rr_next;
  logic              to_hit;

  // Round-robin pick: lowest valid index >= rr_q, else lowest valid overall (wrap).
  always_comb begin
    grant_any = 1'b0;
    found_hi  = 1'b0;
    id_hi     = '0;
    id_lo     = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_any = 1'b1;
        id_lo     = IdW'(i);
        if (IdW'(i) >= rr_q) begin
          found_hi = 1'b1;
          id_hi    = IdW'(i);
        end
      end
    end
    grant_id = found_hi ? id_hi : id_lo;
  end

  // Select the winning requester's transfer fields.
  always_comb begin
    grant_addr = '0;
    grant_size = '0;
    grant_rwn  = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (IdW'(i) == grant_id) begin
        grant_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        grant_size = req_size_i[i*SIZE_W +: SIZE_W];
        grant_rwn  = req_rwn_i[i];
      end
    end
  end

  assign rr_next = (cur_id_q == IdW'(NB_REQ - 1)) ? '0 : cur_id_q + 1'b1;

`ifdef HYPER_TXN_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Watchdog fires when the WAIT-cycle count reaches a nonzero limit.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == StIssue) begin
      to_cnt_d = '0;
    end else if (state_q == StWait) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    to_hit = (state_q == StWait) && (timeout_i != '0) && (to_cnt_q == timeout_i);
  end

  // Watchdog counter register.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign to_hit         = 1'b0;
`endif

  // FSM next-state and transaction capture.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cur_id_d = cur_id_q;
    addr_d   = addr_q;
    size_d   = size_q;
    rwn_d    = rwn_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          cur_id_d = grant_id;
          addr_d   = grant_addr;
          size_d   = grant_size;
          rwn_d    = grant_rwn;
          // A zero-byte request completes without touching the engine.
          state_d  = (grant_size != '0) ? StIssue : StDone;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // EOT takes priority over a coincident timeout.
        if (hyp_eot_i) begin
          state_d = StDone;
        end else if (to_hit) begin
          rr_d    = rr_next;
          state_d = StIdle;
        end
      end
      StDone: begin
        rr_d    = rr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_q     <= '0;
      cur_id_q <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      rwn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cur_id_q <= cur_id_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      rwn_q    <= rwn_d;
    end
  end

  // Output decode; ready is gated by reset so every output is 0 while rst_i is high.
  always_comb begin
    req_ready_o = '0;
    done_o      = '0;
    err_o       = '0;
    if (state_q == StIdle && grant_any && !rst_i) begin
      req_ready_o = NB_REQ'(1) << grant_id;
    end
    if (state_q == StDone) begin
      done_o = NB_REQ'(1) << cur_id_q;
    end
    if (to_hit && !hyp_eot_i) begin
      err_o = NB_REQ'(1) << cur_id_q;
    end
  end

  assign hyp_abort_o = to_hit && !hyp_eot_i;
  assign hyp_start_o = (state_q == StIssue);
  assign rd_eot_o    = (state_q == StDone) && rwn_q;
  assign wr_eot_o    = (state_q == StDone) && !rwn_q;
  assign busy_o      = (state_q != StIdle);
  assign hyp_addr_o  = addr_q;
  assign hyp_size_o  = size_q;
  assign hyp_rwn_o   = rwn_q;
  assign cur_id_o    = cur_id_q;

endmodule

// File: tb/tb_hyper_txn_sched.sv
// Directed testbench for hyper_txn_sched (NB_REQ=4, ADDR_W=32, SIZE_W=16, TO_W=16).
module tb_hyper_txn_sched;

  localparam int unsigned NB_REQ = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SIZE_W = 16;
  localparam int unsigned TO_W   = 16;

  logic                     clk;
  logic                     rst;
  logic [NB_REQ-1:0]        req_valid;
  logic [NB_REQ-1:0]        req_ready;
  logic [NB_REQ*ADDR_W-1:0] req_addr;
  logic [NB_REQ*SIZE_W-1:0] req_size;
  logic [NB_REQ-1:0]        req_rwn;
  logic                     hyp_start;
  logic [ADDR_W-1:0]        hyp_addr;
  logic [SIZE_W-1:0]        hyp_size;
  logic                     hyp_rwn;
  logic                     hyp_eot;
  logic                     hyp_abort;
  logic [TO_W-1:0]          timeout;
  logic [NB_REQ-1:0]        done;
  logic [NB_REQ-1:0]        err;
  logic                     rd_eot;
  logic                     wr_eot;
  logic                     busy;
  logic [1:0]               cur_id;

  int n_checks = 0;
  int n_errors = 0;

  hyper_txn_sched #(
    .NB_REQ (NB_REQ),
    .ADDR_W (ADDR_W),
    .SIZE_W (SIZE_W),
    .TO_W   (TO_W)
  ) dut (
    .sys_clk_i   (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_size_i  (req_size),
    .req_rwn_i   (req_rwn),
    .hyp_start_o (hyp_start),
    .hyp_addr_o  (hyp_addr),
    .hyp_size_o  (hyp_size),
    .hyp_rwn_o   (hyp_rwn),
    .hyp_eot_i   (hyp_eot),
    .hyp_abort_o (hyp_abort),
    .timeout_i   (timeout),
    .done_o      (done),
    .err_o       (err),
    .rd_eot_o    (rd_eot),
    .wr_eot_o    (wr_eot),
    .busy_o      (busy),
    .cur_id_o    (cur_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int rr_order [5] = '{3, 0, 1, 2, 3};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_size  = '0;
    req_rwn   = '0;
    hyp_eot   = 1'b0;
    timeout   = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_addr", hyp_addr, 0);
    chk("rst_size", hyp_size, 0);
    chk("rst_start", hyp_start, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Single read from requester 1; EOT in cycle 10, spurious EOT in IDLE and ISSUE.
    req_valid = 4'b0010;
    req_addr[1*ADDR_W +: ADDR_W] = 32'h1000;
    req_size[1*SIZE_W +: SIZE_W] = 16'd64;
    req_rwn   = 4'b0010;
    hyp_eot   = 1'b1;
    #1;
    chk("rd_ready_c0", req_ready, 4'b0010);
    chk("rd_busy_c0", busy, 0);
    cyc();
    req_valid = '0;
    #1;
    chk("rd_start_c1", hyp_start, 1);
    chk("rd_addr_c1", hyp_addr, 32'h1000);
    chk("rd_size_c1", hyp_size, 64);
    chk("rd_rwn_c1", hyp_rwn, 1);
    chk("rd_id_c1", cur_id, 1);
    hyp_eot = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      cyc();
      #1;
      chk("rd_wait_start", hyp_start, 0);
      chk("rd_wait_done", done, 0);
      chk("rd_wait_busy", busy, 1);
    end
    cyc();
    hyp_eot = 1'b1;
    #1;
    chk("rd_c10_done", done, 0);
    cyc();
    hyp_eot = 1'b0;
    #1;
    chk("rd_c11_done", done, 4'b0010);
    chk("rd_c11_rd_eot", rd_eot, 1);
    chk("rd_c11_wr_eot", wr_eot, 0);
    cyc();
    #1;
    chk("rd_c12_busy", busy, 0);

    // Zero-size write from requester 2 completes without an engine start.
    req_valid = 4'b0100;
    req_addr[2*ADDR_W +: ADDR_W] = 32'hABCD;
    req_size[2*SIZE_W +: SIZE_W] = 16'd0;
    req_rwn   = 4'b0000;
    #1;
    chk("zs_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    #1;
    chk("zs_start", hyp_start, 0);
    chk("zs_done", done, 4'b0100);
    chk("zs_wr_eot", wr_eot, 1);
    chk("zs_rd_eot", rd_eot, 0);
    chk("zs_addr", hyp_addr, 32'hABCD);
    cyc();
    #1;
    chk("zs_idle", busy, 0);
    chk("zs_done_clr", done, 0);

    // Round-robin with all four valid; rr_q is 3 after the zero-size job.
    for (int i = 0; i < NB_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = 32'(i + 1) << 8;
      req_size[i*SIZE_W +: SIZE_W] = 16'(4 * (i + 1));
    end
    req_rwn   = 4'b0101;
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("rr_ready", req_ready, 4'b0001 << rr_order[t]);
      cyc();
      #1;
      chk("rr_start", hyp_start, 1);
      chk("rr_id", cur_id, rr_order[t]);
      chk("rr_addr", hyp_addr, 32'(rr_order[t] + 1) << 8);
      cyc();
      cyc();
      cyc();
      hyp_eot = 1'b1;
      #1;
      cyc();
      hyp_eot = 1'b0;
      #1;
      chk("rr_done", done, 4'b0001 << rr_order[t]);
      chk("rr_rd_eot", rd_eot, (rr_order[t] % 2 == 0) ? 1 : 0);
      chk("rr_wr_eot", wr_eot, (rr_order[t] % 2 == 0) ? 0 : 1);
      cyc();
    end
    req_valid = '0;
    cyc();

`ifdef HYPER_TXN_SCHED_TIMEOUT_EN
    // Timeout on requester 0: error and abort in cycle 22 (20 cycles into WAIT).
    timeout   = 16'd20;
    req_rwn   = 4'b0010;
    req_valid = 4'b0001;
    #1;
    chk("to_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    for (int c = 2; c <= 21; c++) begin
      cyc();
      #1;
      chk("to_err_early", err, 0);
      chk("to_abort_early", hyp_abort, 0);
    end
    cyc();
    #1;
    chk("to_err", err, 4'b0001);
    chk("to_abort", hyp_abort, 1);
    chk("to_no_done", done, 0);
    cyc();
    // Next requester after the timed-out one is preferred.
    req_valid = 4'b0011;
    #1;
    chk("to_next_ready", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    for (int c = 2; c <= 21; c++) begin
      cyc();
    end
    cyc();
    hyp_eot = 1'b1;
    #1;
    chk("co_err", err, 0);
    chk("co_abort", hyp_abort, 0);
    cyc();
    hyp_eot = 1'b0;
    #1;
    chk("co_done", done, 4'b0010);
    chk("co_rd_eot", rd_eot, 1);
    cyc();
`else
    // Watchdog absent: a long wait never errors; WAIT leaves only on EOT.
    timeout   = 16'd20;
    req_rwn   = 4'b0000;
    req_valid = 4'b0001;
    #1;
    chk("nt_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    for (int c = 2; c <= 31; c++) begin
      cyc();
      #1;
      chk("nt_err", err, 0);
      chk("nt_abort", hyp_abort, 0);
      chk("nt_busy", busy, 1);
    end
    cyc();
    hyp_eot = 1'b1;
    #1;
    cyc();
    hyp_eot = 1'b0;
    #1;
    chk("nt_done", done, 4'b0001);
    chk("nt_wr_eot", wr_eot, 1);
    cyc();
`endif

    // Async reset while in WAIT drops the job; re-grant scans from requester 0.
    timeout   = '0;
    req_rwn   = 4'b0100;
    req_valid = 4'b0100;
    #1;
    chk("ar_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    #1;
    chk("ar_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_cur_id", cur_id, 0);
    chk("ar_addr", hyp_addr, 0);
    chk("ar_size", hyp_size, 0);
    chk("ar_rwn", hyp_rwn, 0);
    chk("ar_start", hyp_start, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    req_valid = 4'b1010;
    #1;
    chk("ar_ready_rst", req_ready, 0);
    cyc();
    #1;
    chk("ar_done_hold", done, 0);
    rst = 1'b0;
    #1;
    chk("ar_regrant", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    #1;
    chk("ar_regrant_id", cur_id, 1);
    chk("ar_regrant_start", hyp_start, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
